// File: rtl/hdp_frame_streamer_if.sv
// HDP frame streamer bus: FIFO pop side, HDP panel side and control/status.
// Pure wiring; no latency of its own.
// The FIFO pop strobe is the only backpressure path; panel outputs are never stalled.
`timescale 1ns/1ps
interface hdp_frame_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 1280
);
  localparam int LW = $clog2(LINES) + 1;

  // control / status
  logic                  i_enable;
  logic                  i_clearStatus;
  logic                  o_underflow;
  // first-word-fall-through FIFO head
  logic [DATA_WIDTH-1:0] i_fifoData;
  logic                  i_fifoEmpty;
  logic                  o_fifoRead;
  // HDP panel bus
  logic [DATA_WIDTH-1:0] o_lcdData;
  logic                  o_valid;
  logic                  o_update;
  logic                  o_sync;
  logic                  o_invert;
  logic [LW-1:0]         o_lineCount;
  logic                  o_frameDone;

  // streamer side
  modport master (
    input  i_enable, i_clearStatus, i_fifoData, i_fifoEmpty,
    output o_underflow, o_fifoRead, o_lcdData, o_valid, o_update,
           o_sync, o_invert, o_lineCount, o_frameDone
  );

  // environment side (FIFO + panel + controller)
  modport slave (
    output i_enable, i_clearStatus, i_fifoData, i_fifoEmpty,
    input  o_underflow, o_fifoRead, o_lcdData, o_valid, o_update,
           o_sync, o_invert, o_lineCount, o_frameDone
  );
endinterface

// File: rtl/hdp_frame_streamer.sv
// HDP panel frame streamer: pops FWFT FIFO words and frames them as lines/blanking/back porch.
// Latency 1: a pop at cycle n shows on o_lcdData/o_valid/o_update/o_sync at n+1.
// Empty FIFO in an active line stalls all counters (sticky o_underflow); HDP_INVERT_TOGGLE_EN adds per-frame o_invert toggling.
`timescale 1ns/1ps
module hdp_frame_streamer #(
  parameter int DATA_WIDTH     = 32,
  parameter int LINE_PACKETS   = 40,
  parameter int BLANK_PACKETS  = 4,
  parameter int LINES          = 1280,
  parameter int BACK_PORCH     = 24,
  parameter int UPDATE_PACKETS = 28
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  hdp_frame_streamer_if.master  bus
);

  localparam int FRAME_SLOTS = LINES * (LINE_PACKETS + BLANK_PACKETS) + BACK_PORCH;
  localparam int SW          = $clog2(FRAME_SLOTS + 1);
  localparam int LW          = $clog2(LINES) + 1;
  // one counter serves data, blank and porch phases, so size it for the longest
  localparam int PMAX_A      = (LINE_PACKETS > BLANK_PACKETS) ? LINE_PACKETS : BLANK_PACKETS;
  localparam int PMAX        = (PMAX_A > BACK_PORCH) ? PMAX_A : BACK_PORCH;
  localparam int PW          = $clog2(PMAX + 1);

  localparam logic [PW-1:0] LAST_DATA  = PW'(LINE_PACKETS - 1);
  localparam logic [PW-1:0] LAST_BLANK = PW'(BLANK_PACKETS - 1);
  localparam logic [PW-1:0] LAST_PORCH = PW'(BACK_PORCH - 1);
  localparam logic [LW-1:0] LAST_LINE  = LW'(LINES - 1);
  localparam logic [SW-1:0] UPD_SLOTS  = SW'(UPDATE_PACKETS);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_ACTIVE     = 2'd1,
    S_LINE_BLANK = 2'd2,
    S_BACK_PORCH = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         pkt_q, pkt_d;
  logic [LW-1:0]         line_q, line_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [DATA_WIDTH-1:0] lcd_q, lcd_d;
  logic                  valid_q, valid_d;
  logic                  update_q, update_d;
  logic                  sync_q, sync_d;
  logic                  done_q, done_d;
  logic                  underflow_q, underflow_d;
  logic                  fifo_read;

  // Next state, counter advance and next output beat for the current slot.
  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    line_d      = line_q;
    slot_d      = slot_q;
    lcd_d       = lcd_q;
    valid_d     = 1'b0;
    update_d    = 1'b0;
    sync_d      = 1'b0;
    done_d      = 1'b0;
    fifo_read   = 1'b0;
    underflow_d = underflow_q & ~bus.i_clearStatus;

    case (state_q)
      S_IDLE: begin
        pkt_d  = '0;
        line_d = '0;
        slot_d = '0;
        if (bus.i_enable) begin
          state_d = S_ACTIVE;
        end
      end

      S_ACTIVE: begin
        if (!bus.i_fifoEmpty) begin
          fifo_read = 1'b1;
          lcd_d     = bus.i_fifoData;
          valid_d   = 1'b1;
          update_d  = (slot_q < UPD_SLOTS);
          sync_d    = (line_q == '0) && (pkt_q == '0);
          slot_d    = slot_q + SW'(1);
          if (pkt_q == LAST_DATA) begin
            pkt_d   = '0;
            state_d = S_LINE_BLANK;
          end else begin
            pkt_d = pkt_q + PW'(1);
          end
        end else begin
          // stall: counters and panel data frozen, beat suppressed
          underflow_d = 1'b1;
        end
      end

      S_LINE_BLANK: begin
        lcd_d    = '0;
        update_d = (slot_q < UPD_SLOTS);
        slot_d   = slot_q + SW'(1);
        if (pkt_q == LAST_BLANK) begin
          pkt_d   = '0;
          line_d  = line_q + LW'(1);
          state_d = (line_q == LAST_LINE) ? S_BACK_PORCH : S_ACTIVE;
        end else begin
          pkt_d = pkt_q + PW'(1);
        end
      end

      S_BACK_PORCH: begin
        lcd_d    = '0;
        update_d = (slot_q < UPD_SLOTS);
        if (pkt_q == LAST_PORCH) begin
          // enable is only looked at here, so a frame always runs to completion
          done_d  = 1'b1;
          pkt_d   = '0;
          line_d  = '0;
          slot_d  = '0;
          state_d = bus.i_enable ? S_ACTIVE : S_IDLE;
        end else begin
          pkt_d  = pkt_q + PW'(1);
          slot_d = slot_q + SW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // no pop may leave the FIFO in a cycle that is being reset
    if (i_reset) begin
      fifo_read = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Counters, registered panel beat and sticky underflow.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pkt_q       <= '0;
      line_q      <= '0;
      slot_q      <= '0;
      lcd_q       <= '0;
      valid_q     <= 1'b0;
      update_q    <= 1'b0;
      sync_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      pkt_q       <= pkt_d;
      line_q      <= line_d;
      slot_q      <= slot_d;
      lcd_q       <= lcd_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      sync_q      <= sync_d;
      done_q      <= done_d;
      underflow_q <= underflow_d;
    end
  end

`ifdef HDP_INVERT_TOGGLE_EN
  logic invert_q;

  // Flip polarity on the same edge that raises o_frameDone so the next frame starts with the new value.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      invert_q <= 1'b0;
    end else if (done_d) begin
      invert_q <= ~invert_q;
    end
  end

  assign bus.o_invert = invert_q;
`else
  assign bus.o_invert = 1'b0;
`endif

  assign bus.o_fifoRead  = fifo_read;
  assign bus.o_lcdData   = lcd_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_update    = update_q;
  assign bus.o_sync      = sync_q;
  assign bus.o_lineCount = line_q;
  assign bus.o_frameDone = done_q;
  assign bus.o_underflow = underflow_q;

endmodule
